alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, 16, operand/result width.
REQ-002 Parameter: ALU_LAT, 1, WAIT cycles between issue and result sample (1..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1  requester 0/1 requests an ALU operation; held high until its gnt.
REQ-006 op0 / op1  in  4  requester 0/1 ALU control code.
REQ-007 a0, b0 / a1, b1  in  DW  requester 0/1 operands A, B.
REQ-008 gnt0 / gnt1  out  1  one-cycle pulse: request accepted, operands captured.
REQ-009 alu_ctrl  out  4  control code to shared ALU.
REQ-010 alu_a, alu_b  out  DW  operands to shared ALU.
REQ-011 alu_result  in  DW  shared ALU result.
REQ-012 alu_overflow  in  1  shared ALU overflow flag.
REQ-013 done0 / done1  out  1  one-cycle pulse: response for requester 0/1 valid.
REQ-014 resp_data  out  DW  result, valid only while done0 or done1 high.
REQ-015 resp_ovf  out  1  captured overflow, valid with done.
REQ-016 resp_err  out  1  illegal op code, valid with done.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT, RESP; one-hot or binary is implementer's choice.
REQ-019 Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all others illegal.
REQ-020 IDLE, no req: stay IDLE; gnt0/gnt1 low.
REQ-021 IDLE, any req: grant exactly one requester, pulse its gnt that cycle, capture its op/a/b and owner id into internal registers.
REQ-022 Both req in same cycle: grant the requester not served last (round-robin); last-served register resets to 1, so requester 0 wins the first tie.
REQ-023 Single req: granted regardless of last-served; last-served updates to the granted id on every grant.
REQ-024 After grant, legal op: next state ISSUE; illegal op: next state RESP with err flag set, ALU not used.
REQ-025 alu_ctrl/alu_a/alu_b driven from captured registers at all times; hold 0 in IDLE and after reset.
REQ-026 ISSUE lasts one cycle, then WAIT.
REQ-027 WAIT lasts exactly ALU_LAT cycles via down-counter; on last WAIT cycle register alu_result and alu_overflow, then RESP.
REQ-028 RESP lasts one cycle: assert done of the owner only, drive resp_data/resp_ovf/resp_err from captured registers; next state IDLE.
REQ-029 Latency, legal op, grant in cycle N: done in cycle N+2+ALU_LAT; illegal op: done in cycle N+1.
REQ-030 Illegal op response: resp_data=0, resp_ovf=0, resp_err=1.
REQ-031 Legal op response: resp_err=0.
REQ-032 req ignored in ISSUE, WAIT, RESP; no gnt outside IDLE; a request pending during RESP is considered in the following IDLE cycle.
REQ-033 done0 and done1 never high together; gnt0 and gnt1 never high together.
REQ-034 Requester input changes after gnt have no effect on the in-flight operation.

Reset
REQ-035 reset high at a rising edge: state IDLE, last-served=1, WAIT counter 0, all captured registers 0.
REQ-036 During and after reset: gnt0, gnt1, done0, done1, busy, resp_data, resp_ovf, resp_err, alu_ctrl, alu_a, alu_b all 0.
REQ-037 Reset in ISSUE/WAIT/RESP aborts the operation; no done is issued for it.

Verification
REQ-038 req0, op0=0010, a0=0x0003, b0=0x0004, model ALU ADD, ALU_LAT=1 -> gnt0 cycle N, done0 cycle N+3, resp_data=0x0007, resp_err=0.
REQ-039 req0 and req1 asserted same cycle after reset, both held -> gnt0 first; after done0, gnt1 next IDLE cycle; third tie -> gnt0.
REQ-040 req1, op1=0011 -> gnt1 cycle N, done1 cycle N+1, resp_err=1, resp_data=0, alu_ctrl stays 0.
REQ-041 op0=0010, a0=0x7FFF, b0=0x0001, model ALU asserts overflow -> resp_data=0x8000, resp_ovf=1.
REQ-042 reset asserted during WAIT of a req0 op -> no done0, busy=0 next cycle, next req1 granted with gnt1.
REQ-043 ALU_LAT=4, op0=0110, a0=0x000A, b0=0x0003 -> done0 cycle N+6, resp_data=0x0007; req1 raised in WAIT gets no gnt until IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end sharing one multi-cycle ALU
module alu_arbiter #(
    parameter int DW = 16,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [3:0]    op0,
    input  logic [3:0]    op1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_overflow,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] resp_data,
    output logic          resp_ovf,
    output logic          resp_err,
    output logic          busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          last;
    logic          owner;
    logic [3:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] res_q;
    logic          ovf_q;
    logic          err_q;
    logic          any_req;
    logic          pick;
    logic          legal;
    logic [3:0]    op_sel;
    logic [DW-1:0] a_sel;
    logic [DW-1:0] b_sel;
    logic          grant;
    logic          resp;

    // arbitration: a tie goes to the requester not served last
    always_comb begin
        any_req = req0 | req1;
        pick    = (req0 & req1) ? ~last : req1;
        op_sel  = pick ? op1 : op0;
        a_sel   = pick ? a1 : a0;
        b_sel   = pick ? b1 : b0;
        legal   = op_sel inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    end

    // outputs are forced quiet while reset is asserted
    always_comb begin
        grant     = (state == IDLE) & any_req & ~reset;
        resp      = (state == RESP) & ~reset;
        gnt0      = grant & ~pick;
        gnt1      = grant & pick;
        done0     = resp & ~owner;
        done1     = resp & owner;
        resp_data = resp ? res_q : '0;
        resp_ovf  = resp & ovf_q;
        resp_err  = resp & err_q;
        busy      = (state != IDLE) & ~reset;
        alu_ctrl  = reset ? 4'd0 : op_q;
        alu_a     = reset ? '0 : a_q;
        alu_b     = reset ? '0 : b_q;
    end

    // sequencing: capture on grant, count ALU latency, present one response
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 4'd0;
            owner <= 1'b0;
            op_q  <= 4'd0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    last  <= pick;
                    owner <= pick;
                    op_q  <= legal ? op_sel : 4'd0;
                    a_q   <= legal ? a_sel : '0;
                    b_q   <= legal ? b_sel : '0;
                    err_q <= ~legal;
                    res_q <= '0;
                    ovf_q <= 1'b0;
                    state <= legal ? ISSUE : RESP;
                end
                ISSUE: begin
                    cnt   <= LAT_M1;
                    state <= WAIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    res_q <= alu_result;
                    ovf_q <= alu_overflow;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    op_q  <= 4'd0;
                    a_q   <= '0;
                    b_q   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a timeline reference model for alu_arbiter
module tb_alu_arbiter;
    localparam int DW = 16;
    localparam int LAT = 4;

    logic clk = 0;
    logic reset = 1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic req0 = 0, req1 = 0;
    logic [3:0] op0 = 0, op1 = 0;
    logic [DW-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic gnt0, gnt1, done0, done1, busy, resp_ovf, resp_err, alu_overflow;
    logic [3:0] alu_ctrl;
    logic [DW-1:0] alu_a, alu_b, alu_result, resp_data;

    logic s_req0 = 0, s_req1 = 0;
    logic [3:0] s_op0 = 0, s_op1 = 0;
    logic [DW-1:0] s_a0 = 0, s_b0 = 0, s_a1 = 0, s_b1 = 0;
    logic s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_resp_ovf, s_resp_err, s_alu_overflow;
    logic [3:0] s_alu_ctrl;
    logic [DW-1:0] s_alu_a, s_alu_b, s_alu_result, s_resp_data;

    function automatic logic [16:0] alu_f(logic [3:0] c, logic [15:0] a, logic [15:0] b);
        logic [15:0] r;
        logic o;
        r = 0;
        o = 0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h6: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
            4'h7: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'hC: r = ~(a | b);
            default: r = 0;
        endcase
        return {o, r};
    endfunction

    function automatic bit is_legal(logic [3:0] c);
        return c inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] t [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
        return ($urandom_range(0, 4) == 0) ? 4'($urandom) : t[$urandom_range(0, 5)];
    endfunction

    function automatic logic [15:0] pick_val();
        return ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
    endfunction

    assign {alu_overflow, alu_result} = alu_f(alu_ctrl, alu_a, alu_b);
    assign {s_alu_overflow, s_alu_result} = alu_f(s_alu_ctrl, s_alu_a, s_alu_b);

    alu_arbiter #(.DW(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .done0(done0), .done1(done1), .resp_data(resp_data),
        .resp_ovf(resp_ovf), .resp_err(resp_err), .busy(busy)
    );

    alu_arbiter #(.DW(DW), .ALU_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req0(s_req0), .req1(s_req1), .op0(s_op0), .op1(s_op1),
        .a0(s_a0), .b0(s_b0), .a1(s_a1), .b1(s_b1), .gnt0(s_gnt0), .gnt1(s_gnt1),
        .alu_ctrl(s_alu_ctrl), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
        .alu_overflow(s_alu_overflow), .done0(s_done0), .done1(s_done1), .resp_data(s_resp_data),
        .resp_ovf(s_resp_ovf), .resp_err(s_resp_err), .busy(s_busy)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int who;
        logic [15:0] data;
        logic ovf;
        logic err;
        int at;
    } resp_t;

    resp_t q[$];
    int free_cyc = 0;
    bit last = 1;
    int act_lo = 0;
    int act_hi = -1;
    logic [35:0] cur = 0;

    // reference model: the arbiter is free again the cycle after each response
    always @(negedge clk) begin
        bit idle;
        int w;
        logic [3:0] o;
        logic [15:0] a, b;
        logic [16:0] f;
        resp_t r;
        if (reset) begin
            check("reset_outputs", 64'({gnt0, gnt1, done0, done1, busy, resp_ovf, resp_err,
                                         resp_data, alu_ctrl, alu_a, alu_b}), 64'd0);
            q.delete();
            last = 1;
            free_cyc = cyc + 1;
            act_hi = -1;
        end else begin
            idle = cyc >= free_cyc;
            check("busy", 64'(busy), 64'(!idle));
            check("alu_bus", 64'({alu_ctrl, alu_a, alu_b}),
                  64'((cyc >= act_lo && cyc <= act_hi) ? cur : 36'h0));
            w = -1;
            if (idle && (req0 || req1)) w = (req0 && req1) ? (last ? 0 : 1) : (req1 ? 1 : 0);
            check("gnt", 64'({gnt1, gnt0}), 64'((w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01)));
            if (w >= 0) begin
                o = (w == 1) ? op1 : op0;
                a = (w == 1) ? a1 : a0;
                b = (w == 1) ? b1 : b0;
                r.who = w;
                if (is_legal(o)) begin
                    f = alu_f(o, a, b);
                    r.data = f[15:0];
                    r.ovf = f[16];
                    r.err = 0;
                    r.at = cyc + 2 + LAT;
                    cur = {o, a, b};
                    act_lo = cyc + 1;
                    act_hi = r.at;
                end else begin
                    r.data = 0;
                    r.ovf = 0;
                    r.err = 1;
                    r.at = cyc + 1;
                    act_hi = -1;
                end
                q.push_back(r);
                free_cyc = r.at + 1;
                last = (w == 1);
            end
        end
    end

    // monitor: every done pops one expected response
    always @(negedge clk) begin
        resp_t r;
        if (!reset) begin
            check("done_exclusive", 64'(done0 & done1), 64'd0);
            if (done0 || done1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: got done%0d expected none (cycle %0d)", done1, cyc);
                end else begin
                    r = q.pop_front();
                    check("resp_owner", 64'({done1, done0}), 64'((r.who == 1) ? 2'b10 : 2'b01));
                    check("resp_cycle", 64'(cyc), 64'(r.at));
                    check("resp_payload", 64'({resp_err, resp_ovf, resp_data}), 64'({r.err, r.ovf, r.data}));
                end
            end else if (q.size() != 0 && q[0].at < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing_done: got none expected done%0d at cycle %0d", q[0].who, q[0].at);
                void'(q.pop_front());
            end
        end
    end

    task automatic step(bit rnd);
        bit g0, g1;
        @(negedge clk);
        g0 = gnt0;
        g1 = gnt1;
        @(posedge clk);
        #1;
        if (reset) reset = 0;
        if (g0) begin
            req0 = 0; op0 = 4'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
        end else if (rnd && !req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1; op0 = pick_op(); a0 = pick_val(); b0 = pick_val();
        end
        if (g1) begin
            req1 = 0; op1 = 4'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        end else if (rnd && !req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1; op1 = pick_op(); a1 = pick_val(); b1 = pick_val();
        end
        if (rnd && $urandom_range(0, 199) == 0) reset = 1;
    endtask

    task automatic one1(bit w, logic [3:0] o, logic [15:0] a, logic [15:0] b, int lat,
                        logic [15:0] ed, logic eo, logic ee);
        int gc;
        bit got;
        bit alu_nz;
        @(posedge clk);
        #1;
        if (w) begin s_req1 = 1; s_op1 = o; s_a1 = a; s_b1 = b; end
        else begin s_req0 = 1; s_op0 = o; s_a0 = a; s_b0 = b; end
        got = 0;
        gc = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (w ? s_gnt1 : s_gnt0) begin got = 1; gc = cyc; end
        end
        check("lat1_gnt", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        s_req0 = 0; s_req1 = 0;
        s_op0 = 4'hF; s_op1 = 4'hF; s_a0 = 16'hFFFF; s_b0 = 16'hFFFF; s_a1 = 16'hFFFF; s_b1 = 16'hFFFF;
        got = 0;
        alu_nz = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            alu_nz |= (s_alu_ctrl != 0);
            if (s_done0 || s_done1) begin
                got = 1;
                check("lat1_owner", 64'({s_done1, s_done0}), 64'(w ? 2'b10 : 2'b01));
                check("lat1_latency", 64'(cyc - gc), 64'(lat));
                check("lat1_resp", 64'({s_resp_err, s_resp_ovf, s_resp_data}), 64'({ee, eo, ed}));
            end
        end
        check("lat1_done_seen", 64'(got), 64'd1);
        if (ee) check("lat1_alu_idle", 64'(alu_nz), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        one1(0, 4'h2, 16'h0003, 16'h0004, 3, 16'h0007, 0, 0);
        one1(1, 4'h3, 16'h1234, 16'h0001, 1, 16'h0000, 0, 1);
        one1(0, 4'h2, 16'h7FFF, 16'h0001, 3, 16'h8000, 1, 0);
        one1(1, 4'h7, 16'hFFFF, 16'h0001, 3, 16'h0001, 0, 0);
        one1(0, 4'hC, 16'h00F0, 16'h0F00, 3, 16'hF00F, 0, 0);
        one1(1, 4'h6, 16'h0000, 16'h0001, 3, 16'hFFFF, 0, 0);
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            req0 = 1; op0 = 4'h2; a0 = pick_val(); b0 = pick_val();
            req1 = 1; op1 = 4'h1; a1 = pick_val(); b1 = pick_val();
            repeat (25) step(0);
        end
        req0 = 1; op0 = 4'h6; a0 = 16'h000A; b0 = 16'h0003;
        repeat (3) step(0);
        req1 = 1; op1 = 4'h0; a1 = 16'hF0F0; b1 = 16'h0FF0;
        repeat (20) step(0);
        req0 = 1; op0 = 4'h2; a0 = 16'h0011; b0 = 16'h0022;
        repeat (4) step(0);
        reset = 1;
        req1 = 1; op1 = 4'h7; a1 = 16'h0001; b1 = 16'h0002;
        repeat (20) step(0);
        repeat (3000) step(1);
        repeat (40) step(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
